// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the program_ram data port between two masters,
// with a tag pipeline that returns read data to the issuing master.

module ram_port_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req,
  input  logic                  gnt,
  input  logic                  stall_clr,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)      rdata <= '0;
    else if (capture) rdata <= ram_data_in;
  end

  // Clear wins over increment; the counter parks at all-ones.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                           stall_count <= '0;
    else if (stall_clr)                    stall_count <= '0;
    else if (req && !gnt && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end

endmodule

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    m0_req_in,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_in,
  input  logic [DATA_WIDTH-1:0]   m0_data_in,
  input  logic [DATA_WIDTH/8-1:0] m0_we_in,
  output logic                    m0_gnt_out,
  output logic                    m0_rvalid_out,
  output logic [DATA_WIDTH-1:0]   m0_rdata_out,
  input  logic                    m1_req_in,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_in,
  input  logic [DATA_WIDTH-1:0]   m1_data_in,
  input  logic [DATA_WIDTH/8-1:0] m1_we_in,
  output logic                    m1_gnt_out,
  output logic                    m1_rvalid_out,
  output logic [DATA_WIDTH-1:0]   m1_rdata_out,
  output logic [ADDR_WIDTH-1:0]   ram_addr_out,
  output logic [DATA_WIDTH-1:0]   ram_data_out,
  output logic [DATA_WIDTH/8-1:0] ram_we_out,
  input  logic [DATA_WIDTH-1:0]   ram_data_in,
  input  logic                    stall_clr_in,
  output logic [CNT_WIDTH-1:0]    m0_stall_count_out,
  output logic [CNT_WIDTH-1:0]    m1_stall_count_out
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int NM   = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       we;
  } mreq_t;

  mreq_t [NM-1:0]                 mreq;
  mreq_t                          sel;
  logic  [NM-1:0]                 req, gnt, rvalid;
  logic  [NM-1:0][DATA_WIDTH-1:0] rdata;
  logic  [NM-1:0][CNT_WIDTH-1:0]  stall;
  logic                           last_grant, win, issue;
  logic  [RD_LATENCY:0]           vld_pipe, id_pipe;

  assign mreq[0] = {m0_addr_in, m0_data_in, m0_we_in};
  assign mreq[1] = {m1_addr_in, m1_data_in, m1_we_in};
  assign req     = {m1_req_in, m0_req_in};

  // Under contention the master that did not win last time goes first.
  assign gnt[0] = req[0] & (~req[1] | last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);
  assign win    = gnt[1];
  assign issue  = |gnt;
  assign sel    = mreq[win];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)    last_grant <= 1'b1;
    else if (issue) last_grant <= win;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ram_addr_out <= '0;
      ram_data_out <= '0;
      ram_we_out   <= '0;
    end else if (issue) begin
      ram_addr_out <= sel.addr;
      ram_data_out <= sel.data;
      ram_we_out   <= sel.we;
    end else begin
      ram_we_out   <= '0;
    end
  end

  // Stage k is visible k+1 cycles after the grant cycle; ram_data_in is
  // sampled as a tag moves into the last stage so rdata lines up with rvalid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue & (sel.we == '0)};
      id_pipe  <= {id_pipe[RD_LATENCY-1:0], win};
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_lane
    assign rvalid[g] = vld_pipe[RD_LATENCY] & (id_pipe[RD_LATENCY] == 1'(g));

    ram_port_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_lane (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .req         (req[g]),
      .gnt         (gnt[g]),
      .stall_clr   (stall_clr_in),
      .capture     (vld_pipe[RD_LATENCY-1] & (id_pipe[RD_LATENCY-1] == 1'(g))),
      .ram_data_in (ram_data_in),
      .rdata       (rdata[g]),
      .stall_count (stall[g])
    );
  end

  assign m0_gnt_out         = gnt[0];
  assign m1_gnt_out         = gnt[1];
  assign m0_rvalid_out      = rvalid[0];
  assign m1_rvalid_out      = rvalid[1];
  assign m0_rdata_out       = rdata[0];
  assign m1_rdata_out       = rdata[1];
  assign m0_stall_count_out = stall[0];
  assign m1_stall_count_out = stall[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered-read RAM model.

module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m1_req, clr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_data, m1_data;
  logic [3:0]    m0_we, m1_we;
  logic          gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_q;
  logic [3:0]    ram_we;
  logic [CW-1:0] st0, st1;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (2),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_n),
    .m0_req_in          (m0_req),
    .m0_addr_in         (m0_addr),
    .m0_data_in         (m0_data),
    .m0_we_in           (m0_we),
    .m0_gnt_out         (gnt0),
    .m0_rvalid_out      (rv0),
    .m0_rdata_out       (rd0),
    .m1_req_in          (m1_req),
    .m1_addr_in         (m1_addr),
    .m1_data_in         (m1_data),
    .m1_we_in           (m1_we),
    .m1_gnt_out         (gnt1),
    .m1_rvalid_out      (rv1),
    .m1_rdata_out       (rd1),
    .ram_addr_out       (ram_addr),
    .ram_data_out       (ram_wdata),
    .ram_we_out         (ram_we),
    .ram_data_in        (ram_q),
    .stall_clr_in       (clr),
    .m0_stall_count_out (st0),
    .m1_stall_count_out (st1)
  );

  // RAM model: unwritten words read as 0xC0DE_0000 | byte address.
  logic [DW-1:0] mem [0:63];
  logic [63:0]   written = '0;

  function automatic logic [DW-1:0] rd_word(input logic [5:0] idx);
    return written[idx] ? mem[idx] : (32'hC0DE_0000 | {24'd0, idx, 2'b00});
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (ram_we != 4'h0) begin
      w = rd_word(ram_addr[7:2]);
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
      mem[ram_addr[7:2]]     <= w;
      written[ram_addr[7:2]] <= 1'b1;
    end
    ram_q <= rd_word(ram_addr[7:2]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    m0_req = 1'b0; m0_addr = '0; m0_data = '0; m0_we = '0;
    m1_req = 1'b0; m1_addr = '0; m1_data = '0; m1_we = '0;

    // reset state
    mid(); mid();
    chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);
    chk("rst_rv0", rv0, 0);     chk("rst_rv1", rv1, 0);
    chk("rst_we", ram_we, 0);   chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_rd0", rd0, 0);     chk("rst_st0", st0, 0);   chk("rst_st1", st1, 0);
    cyc(); rst_n = 1'b1;

    // single m0 read
    cyc(); m0_req = 1'b1; m0_addr = 32'h10; m0_we = 4'h0;
    mid(); chk("t1_gnt0", gnt0, 1); chk("t1_gnt1", gnt1, 0);
    cyc(); m0_req = 1'b0;
    mid(); chk("t1_addr", ram_addr, 32'h10); chk("t1_we", ram_we, 0);
    cyc(); mid(); chk("t1_rv0_early", rv0, 0);
    cyc(); mid(); chk("t1_rv0", rv0, 1); chk("t1_rd0", rd0, 32'hC0DE_0010); chk("t1_rv1", rv1, 0);
    cyc(); mid(); chk("t1_rv0_off", rv0, 0); chk("t1_rd0_hold", rd0, 32'hC0DE_0010);

    // contention from reset: m0 read, m1 write
    do_reset();
    cyc(); m0_req = 1'b1; m0_addr = 32'h20; m0_we = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h30; m1_we = 4'hF; m1_data = 32'hDEAD_BEEF;
    mid(); chk("t2_gnt0", gnt0, 1); chk("t2_gnt1", gnt1, 0);
    cyc(); m0_req = 1'b0;
    mid(); chk("t2_gnt1b", gnt1, 1); chk("t2_gnt0b", gnt0, 0);
    chk("t2_addr_rd", ram_addr, 32'h20); chk("t2_we_rd", ram_we, 0);
    cyc(); m1_req = 1'b0; m1_we = 4'h0;
    mid(); chk("t2_we", ram_we, 4'hF); chk("t2_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("t2_waddr", ram_addr, 32'h30); chk("t2_st1", st1, 1); chk("t2_st0", st0, 0);
    cyc(); mid(); chk("t2_we_idle", ram_we, 0); chk("t2_rv0", rv0, 1);
    chk("t2_rd0", rd0, 32'hC0DE_0020); chk("t2_rv1", rv1, 0);
    cyc(); mid(); chk("t2_rv0_off", rv0, 0); chk("t2_rv1_wr", rv1, 0);

    // 8 cycles of contention, strict alternation
    cyc(); clr = 1'b1;
    cyc(); clr = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h4; m1_we = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      mid();
      chk("t3_gnt0", gnt0, (i % 2 == 0));
      chk("t3_gnt1", gnt1, (i % 2 == 1));
    end
    cyc(); m0_req = 1'b0; m1_req = 1'b0;
    mid(); chk("t3_st0", st0, 4); chk("t3_st1", st1, 4);

    // m1 back-to-back reads, then write/read of 0x40
    for (int i = 0; i < 10; i++) begin
      cyc();
      m1_req = (i < 6);
      m1_addr = (i < 4) ? 32'h50 + 32'(i * 4) : 32'h40;
      m1_we = (i == 4) ? 4'b0011 : 4'h0;
      m1_data = 32'h0000_ABCD;
      mid();
      if (i < 6) chk("t4_gnt1", gnt1, 1);
      if (i >= 3 && i <= 6) begin
        chk("t4_rv1", rv1, 1);
        chk("t4_rd1", rd1, 32'hC0DE_0050 + 32'((i - 3) * 4));
      end
      if (i == 7) chk("t4_rv1_wr", rv1, 0);
      if (i == 8) begin
        chk("t4_rv1_raw", rv1, 1);
        chk("t4_rd1_raw", rd1, 32'hC0DE_ABCD);
        chk("t4_rv0", rv0, 0);
      end
    end

    // stall counter saturation and clear
    cyc(); clr = 1'b1;
    cyc(); clr = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h8; m1_addr = 32'hC;
    repeat (520) cyc();
    mid(); chk("t5_sat0", st0, 8'hFF); chk("t5_sat1", st1, 8'hFF);
    repeat (3) cyc();
    mid(); chk("t5_hold0", st0, 8'hFF); chk("t5_hold1", st1, 8'hFF);
    cyc(); clr = 1'b1;
    mid(); chk("t5_preclr", st0, 8'hFF);
    cyc(); clr = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    mid(); chk("t5_clr0", st0, 0); chk("t5_clr1", st1, 0);

    // reset mid-read discards the outstanding tag
    cyc(); m0_req = 1'b1; m0_addr = 32'h10;
    mid(); chk("t6_gnt0", gnt0, 1);
    cyc(); m0_req = 1'b0; rst_n = 1'b0;
    mid(); chk("t6_rst_addr", ram_addr, 0); chk("t6_rst_rv0", rv0, 0);
    cyc(); rst_n = 1'b1;
    mid(); chk("t6_rv0_a", rv0, 0);
    cyc(); mid(); chk("t6_rv0_b", rv0, 0);
    cyc(); m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h4;
    mid(); chk("t6_gnt0", gnt0, 1); chk("t6_gnt1", gnt1, 0);
    cyc(); m0_req = 1'b0; m1_req = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
